// File: rtl/cmp_scan_pkg.sv
// Shared definitions for the comparator-based key-match scanner.
package cmp_scan_pkg;

  // Comparator width is fixed by the 8-bit identity comparator part.
  localparam int unsigned TAG_W = 8;

  // Scanner control states, 2-bit binary encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/MOD_74x688.sv
// 8-bit identity comparator: Y is high when A equals B.
module MOD_74x688 (
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic       Y
);

  // Bitwise equality reduced to a single match flag.
  always_comb begin
    Y = (A == B);
  end

endmodule

// File: rtl/cmp_scan_ctrl.sv
// Sequential key-match scanner: walks a tag table one entry per clock through
// a single shared equality comparator and reports the first valid match.
module cmp_scan_ctrl
  import cmp_scan_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [7:0]       KEY,
  input  logic             LOAD_EN,
  input  logic [IDX_W-1:0] LOAD_ADDR,
  input  logic [7:0]       LOAD_DATA,
  input  logic             LOAD_VALID,
  output logic             BUSY,
  output logic             DONE,
  output logic             HIT,
  output logic [IDX_W-1:0] HIT_IDX
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [TAG_W-1:0]   r_tag [DEPTH];
  logic [DEPTH-1:0]   r_valid;
  logic [IDX_W-1:0]   r_idx;
  logic [TAG_W-1:0]   r_key;
  logic               r_hit;
  logic [IDX_W-1:0]   r_hit_idx;

  logic [TAG_W-1:0]   w_tag_rd;
  logic               w_eq;
  logic               w_match;
  logic               w_last;
  logic               w_load;

  // Table read mux and scan qualifiers.
  always_comb begin
    w_tag_rd = r_tag[r_idx];
    w_match  = w_eq & r_valid[r_idx];
    w_last   = (r_idx == IDX_W'(DEPTH - 1));
    w_load   = (r_state == ST_IDLE) && LOAD_EN;
  end

  MOD_74x688 u_cmp (
    .A (w_tag_rd),
    .B (r_key),
    .Y (w_eq)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: REPORT always lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (START) w_state_nxt = ST_SCAN;
      ST_SCAN:   if (w_match || w_last) w_state_nxt = ST_REPORT;
      ST_REPORT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    BUSY = (r_state != ST_IDLE);
    DONE = (r_state == ST_REPORT);
  end

  // Tag storage; contents are don't-care after reset, only the valid bits matter.
  always_ff @(posedge CLK) begin
    if (RST_N && w_load) r_tag[LOAD_ADDR] <= LOAD_DATA;
  end

  // Valid bits, key latch, scan index and result registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_valid   <= '0;
      r_idx     <= '0;
      r_key     <= '0;
      r_hit     <= 1'b0;
      r_hit_idx <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (LOAD_EN) r_valid[LOAD_ADDR] <= LOAD_VALID;
          if (START) begin
            r_key <= KEY;
            r_idx <= '0;
          end
        end
        ST_SCAN: begin
          if (w_match) begin
            r_hit     <= 1'b1;
            r_hit_idx <= r_idx;
          end else if (w_last) begin
            r_hit     <= 1'b0;
            r_hit_idx <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign HIT     = r_hit;
  assign HIT_IDX = r_hit_idx;

endmodule
